mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 31 +++
 rtl/mem_lane_merge.sv | 25 ++
 rtl/mem_responder.sv | 161 ++++++++++++++++
 tb/tb_mem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: access-size encodings,
// FSM state encoding, default geometry/timing and a lane-mask helper.
package mem_resp_pkg;

    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_WAIT_CYCLES = 2;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_MERGE  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // Right-aligned mask covering the bytes touched by an access of this size.
    function automatic logic [31:0] lane_mask(input logic [1:0] size);
        case (size)
            SIZE_WORD: return 32'hFFFF_FFFF;
            SIZE_HALF: return 32'h0000_FFFF;
            SIZE_BYTE: return 32'h0000_00FF;
            default:   return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Byte-lane extraction and write merge for little-endian sub-word accesses.
// offset must already be aligned to the access size.
module mem_lane_merge
    import mem_resp_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] lane,
    output logic [31:0] merged
);

    logic [4:0]  shift;
    logic [31:0] mask;

    // Shift the selected lane down for reads, and the write data up into place.
    always_comb begin
        shift  = {offset, 3'b000};
        mask   = lane_mask(size);
        lane   = (word >> shift) & mask;
        merged = (word & ~(mask << shift)) | ((wdata & mask) << shift);
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: single-outstanding request/ack slave with a fixed number
// of wait states and read-modify-write for sub-word stores.
// Optional build macro: MEM_ALIGN_CHECK_EN -- misaligned halfword/word
// accesses fail with err instead of having their low address bits dropped.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for req; captures the request when it arrives
// WAIT   | wait-state countdown
// ACCESS | read addressed word; word stores written here
// MERGE  | sub-word store: write back word with selected lanes replaced
// RESP   | ack (with err/rdata) for one cycle
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t             state, state_nxt;
    logic [3:0]         wait_cnt;
    logic               we_q;
    logic [1:0]         size_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               err_q;

    logic [31:0]        mem [DEPTH_WORDS];

    logic [1:0]         offset;
    logic               in_range;
    logic               err_c;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        mem_rd;
    logic [31:0]        lane;
    logic [31:0]        merged;

    // Address decode of the captured request: aligned lane offset, range and error.
    always_comb begin
        case (size_q)
            SIZE_WORD: offset = 2'b00;
            SIZE_HALF: offset = {addr_q[1], 1'b0};
            default:   offset = addr_q[1:0];
        endcase
        in_range = ({2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS));
        idx      = addr_q[IDX_W+1:2];
        mem_rd   = in_range ? mem[idx] : 32'h0;
`ifdef MEM_ALIGN_CHECK_EN
        err_c = (size_q == SIZE_RSVD) || !in_range
              || ((size_q == SIZE_HALF) && addr_q[0])
              || ((size_q == SIZE_WORD) && (addr_q[1:0] != 2'b00));
`else
        err_c = (size_q == SIZE_RSVD) || !in_range;
`endif
    end

    mem_lane_merge u_lane_merge (
        .size   (size_q),
        .offset (offset),
        .word   (mem_rd),
        .wdata  (wdata_q),
        .lane   (lane),
        .merged (merged)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt = state;
        ack       = 1'b0;
        err       = 1'b0;
        rdata     = 32'h0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (req) state_nxt = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (err_c || !we_q || (size_q == SIZE_WORD)) state_nxt = ST_RESP;
                else                                         state_nxt = ST_MERGE;
            end
            ST_MERGE: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                ack       = 1'b1;
                err       = err_q;
                rdata     = rdata_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request capture, wait-state down-counter and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 4'd0;
            we_q     <= 1'b0;
            size_q   <= SIZE_WORD;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        we_q     <= we;
                        size_q   <= size;
                        addr_q   <= addr;
                        wdata_q  <= wdata;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                end
                ST_ACCESS: begin
                    err_q   <= err_c;
                    rdata_q <= (err_c || we_q) ? 32'h0 : lane;
                end
                default: ;
            endcase
        end
    end

    // Storage writes; contents deliberately survive reset. A word store's
    // merged value is the full write data, so one write path serves both.
    always_ff @(posedge clk) begin
        if ((state == ST_ACCESS) && we_q && (size_q == SIZE_WORD) && !err_c)
            mem[idx] <= merged;
        else if (state == ST_MERGE)
            mem[idx] <= merged;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: byte-addressed reference model, per-cycle
// output compare, and directed transactions with literal expectations.
module tb_mem_responder;

    localparam int W = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [1:0]  size  = 2'b00;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ack;
    logic        err;
    logic        busy;
    logic [31:0] rdata;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .size  (size),
        .addr  (addr),
        .wdata (wdata),
        .ack   (ack),
        .rdata (rdata),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte-addressed storage, one outstanding transaction.
    logic [7:0]  mb [1024];
    bit          m_active = 1'b0;
    int          m_start  = 0;
    int          m_len    = 0;
    int          m_eff    = 0;
    bit          m_err    = 1'b0;
    bit          m_we     = 1'b0;
    logic [31:0] m_wdata  = 32'h0;
    logic [31:0] m_rdata  = 32'h0;

    function automatic int nbytes(input logic [1:0] s);
        case (s)
            2'b00:   return 4;
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 0;
        endcase
    endfunction

    task automatic model_start(input logic w, input logic [1:0] s,
                               input logic [31:0] a, input logic [31:0] d);
        m_we    = w;
        m_wdata = d;
        m_err   = (s == 2'b11) || (a >= 32'd1024);
`ifdef MEM_ALIGN_CHECK_EN
        if ((s == 2'b01 && a[0]) || (s == 2'b00 && a[1:0] != 2'b00)) m_err = 1'b1;
`endif
        m_eff = int'(a[9:0]);
        if (s == 2'b00) m_eff = m_eff - (m_eff % 4);
        if (s == 2'b01) m_eff = m_eff - (m_eff % 2);
        m_rdata = 32'h0;
        if (!m_err && !w)
            for (int i = 0; i < nbytes(s); i++)
                m_rdata = m_rdata | (32'(mb[m_eff + i]) << (8 * i));
        m_len    = W + 1 + ((w && s != 2'b00 && !m_err) ? 1 : 0);
        m_start  = cyc;
        m_active = 1'b1;
    endtask

    task automatic model_commit(input int nb);
        if (m_we && !m_err)
            for (int i = 0; i < nb; i++) mb[m_eff + i] = m_wdata[8 * i +: 8];
    endtask

    // Per-cycle compare of DUT outputs against the model.
    bit e_busy, e_ack;
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_busy",  32'(busy),  32'd0);
            chk("rst_ack",   32'(ack),   32'd0);
            chk("rst_err",   32'(err),   32'd0);
            chk("rst_rdata", rdata,      32'd0);
        end else begin
            e_busy = m_active && (cyc >= m_start) && (cyc <= m_start + m_len);
            e_ack  = m_active && (cyc == m_start + m_len);
            chk("busy", 32'(busy), 32'(e_busy));
            chk("ack",  32'(ack),  32'(e_ack));
            if (e_ack) begin
                chk("err", 32'(err), 32'(m_err));
                if (m_err || !m_we) chk("rdata", rdata, m_rdata);
            end
        end
    end

    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;

    // Issue one transaction; req stays high with junk while busy (must be ignored).
    task automatic do_txn(input logic w, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] d);
        bit got;
        req = 1'b1; we = w; size = s; addr = a; wdata = d;
        @(posedge clk); #1;
        model_start(w, s, a, d);
        we = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
        got = 1'b0;
        last_lat = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                got        = 1'b1;
                last_rdata = rdata;
                last_err   = err;
                last_lat   = cyc - m_start;
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
        model_commit(nbytes(s));
        req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        chk("por_busy", 32'(busy), 32'd0);
        chk("por_ack",  32'(ack),  32'd0);
        #2 reset = 1'b1;
        @(negedge clk);

        do_txn(1'b1, 2'b00, 32'h10, 32'hDEADBEEF);
        chk("wr_word_lat", 32'(last_lat), 32'd3);
        chk("wr_word_err", 32'(last_err), 32'd0);
        do_txn(1'b0, 2'b00, 32'h10, 32'h0);
        chk("rd_word_lat", 32'(last_lat), 32'd3);
        chk("rd_word", last_rdata, 32'hDEADBEEF);

        do_txn(1'b1, 2'b10, 32'h11, 32'h123456AB);
        chk("wr_byte_lat", 32'(last_lat), 32'd4);
        chk("wr_byte_err", 32'(last_err), 32'd0);
        do_txn(1'b0, 2'b00, 32'h10, 32'h0);
        chk("rd_after_byte", last_rdata, 32'hDEADABEF);
        do_txn(1'b0, 2'b01, 32'h12, 32'h0);
        chk("rd_half_12", last_rdata, 32'h0000DEAD);
        do_txn(1'b0, 2'b10, 32'h13, 32'h0);
        chk("rd_byte_13", last_rdata, 32'h000000DE);

        do_txn(1'b1, 2'b00, 32'h14, 32'h01020304);
        do_txn(1'b1, 2'b01, 32'h16, 32'hFFFFCAFE);
        chk("wr_half_lat", 32'(last_lat), 32'd4);
        do_txn(1'b0, 2'b00, 32'h14, 32'h0);
        chk("rd_after_half", last_rdata, 32'hCAFE0304);
        do_txn(1'b0, 2'b10, 32'h14, 32'h0);
        chk("rd_byte_14", last_rdata, 32'h00000004);

        do_txn(1'b0, 2'b00, 32'h400, 32'h0);
        chk("oor_err", 32'(last_err), 32'd1);
        chk("oor_rdata", last_rdata, 32'h0);
        chk("oor_lat", 32'(last_lat), 32'd3);
        do_txn(1'b0, 2'b11, 32'h10, 32'h0);
        chk("rsvd_rd_err", 32'(last_err), 32'd1);
        do_txn(1'b1, 2'b11, 32'h10, 32'h0);
        chk("rsvd_wr_err", 32'(last_err), 32'd1);
        chk("rsvd_wr_lat", 32'(last_lat), 32'd3);
        do_txn(1'b1, 2'b10, 32'h400, 32'h55);
        chk("oor_wr_lat", 32'(last_lat), 32'd3);
        do_txn(1'b0, 2'b00, 32'h10, 32'h0);
        chk("no_change", last_rdata, 32'hDEADABEF);

        do_txn(1'b0, 2'b01, 32'h15, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_half_err", 32'(last_err), 32'd1);
`else
        chk("mis_half_rd", last_rdata, 32'h00000304);
`endif
        do_txn(1'b1, 2'b00, 32'h13, 32'h11223344);
        do_txn(1'b0, 2'b00, 32'h10, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_word_rd", last_rdata, 32'hDEADABEF);
`else
        chk("mis_word_rd", last_rdata, 32'h11223344);
`endif

        do_txn(1'b1, 2'b10, 32'h30, 32'h11);
        do_txn(1'b1, 2'b10, 32'h31, 32'h22);
        do_txn(1'b1, 2'b10, 32'h32, 32'h33);
        do_txn(1'b1, 2'b10, 32'h33, 32'h44);
        do_txn(1'b0, 2'b00, 32'h30, 32'h0);
        chk("le_bytes", last_rdata, 32'h44332211);

        do_txn(1'b1, 2'b00, 32'h20, 32'h0BADF00D);
        req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h20; wdata = 32'h12345678;
        @(posedge clk); #1;
        model_start(1'b1, 2'b00, 32'h20, 32'h12345678);
        req = 1'b0;
        @(negedge clk); #2;
        reset = 1'b0;
        m_active = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack",  32'(ack),  32'd0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        do_txn(1'b0, 2'b00, 32'h20, 32'h0);
        chk("abort_keep", last_rdata, 32'h0BADF00D);
        do_txn(1'b0, 2'b00, 32'h10, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("survive_rst", last_rdata, 32'hDEADABEF);
`else
        chk("survive_rst", last_rdata, 32'h11223344);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
